nou_out_interface_unit: RTL and testbench
=========================================

// Module: nou_out_interface_unit
// PURPOSE
// Router-to-NOU output interface. Converts the credit (valid/yummy) protocol into the vld-rdy handshake.
// Buffers flits arriving from the router in a DEPTH-entry FIFO. Splits each flit into tid/type/data fields for the NOU.
// Returns one yummy (credit) to the router per flit consumed by the NOU. Pairs with nou_in_interface_unit on the far side of the router.
// PARAMETERS
// WIDTH      `DATA_WIDTH     flit width; must equal `TID_WIDTH + `TYPE_WIDTH + DAT_WIDTH
// DAT_WIDTH  `DAT_DAT_WIDTH  payload field width
// DEPTH      2               FIFO entries; power of 2, >= 2, >= credits granted upstream
// PTR_BITS   $clog2(DEPTH)   pointer width; count is PTR_BITS+1 bits
// PORTS
// clk                 in   1            clock
// rst                 in   1            reset, asynchronous, active-low
// router_noiu_data    in   WIDTH        flit from router
// router_noiu_valid   in   1            flit valid (credit protocol: no backpressure)
// noiu_router_yummy   out  1            credit return, one pulse per dequeued flit
// noiu_nou_tid        out  `TID_WIDTH   flit[WIDTH-1 -: `TID_WIDTH]
// noiu_nou_type       out  `TYPE_WIDTH  next `TYPE_WIDTH bits below tid
// noiu_nou_data       out  DAT_WIDTH    flit[DAT_WIDTH-1:0]
// noiu_nou_valid      out  1            head flit valid
// nou_noiu_ready      in   1            NOU accepts head flit
// noiu_overflow       out  1            sticky error: flit arrived with FIFO full and no pop
// BEHAVIOUR
// - Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0; yummy=0, valid=0, overflow=0; tid/type/data=0. Storage not reset.
// - push = router_noiu_valid & (count<DEPTH | pop); pop = noiu_nou_valid & nou_noiu_ready.
// - count next = count + push - pop; push&pop together leaves count unchanged, including at full and empty.
// - Pointers wrap naturally modulo DEPTH (power of 2). Flits leave in arrival order.
// - Show-ahead output: noiu_nou_valid = (count!=0). Field outputs decode the head entry combinationally; all zero when empty.
// - No bypass. Flit written at edge N is first visible in cycle N+1, so input-to-output latency is 1 cycle.
// - Valid and fields hold stable while valid=1 & ready=0; guaranteed by FIFO head semantics.
// - Yummy is registered: yummy <= pop. It is high for exactly one cycle, the cycle after each pop.
// - Back-to-back pops give back-to-back yummy cycles. Total yummies == total pops.
// - Overflow: router_noiu_valid & count==DEPTH & !pop drops the flit, leaves FIFO untouched, sets noiu_overflow=1.
// - noiu_overflow clears only on reset. A flit arriving while a full FIFO is popped is accepted (no overflow).
// - Reset mid-operation discards buffered flits; no yummy is ever issued for a discarded flit.
// - The upstream credit counter shares rst, so credits resynchronise on reset.
// - nou_noiu_ready while valid=0 is ignored.
// TESTING
// 1 reset: hold rst=0 with router valid toggling -> all outputs 0; after release valid=0, yummy=0 until a push.
// 2 single flit, DEPTH=2, ready=1: push {tid=3,type=1,data=0xA5} at edge 0 -> valid=1 in cycle 1 with those fields; yummy=1 in cycle 2 only.
// 3 backpressure: ready=0, push F0,F1 -> valid=1 holds F0, no yummy; ready=1 -> F0 then F1 on consecutive cycles, two consecutive yummies one cycle later.
// 4 full push+pop: count=2, ready=1, push F2 the same cycle F0 pops -> count stays 2, overflow=0, order F1,F2.
// 5 overflow: count=2, ready=0, push F2 -> F2 dropped, overflow=1 sticky, head still F0; drain yields F0,F1 only.
// 6 stream+reset: ready=1, push 8 flits on 8 consecutive cycles -> 8 outputs 1 cycle delayed, 8 yummies; repeat with rst pulsed at 2 buffered -> valid=0, no further yummy.

Source files
------------

// File: rtl/nou_out_interface_unit_if.sv
// nou_out_interface_unit_if
// Bundles the router-side credit signals and the NOU-side valid/ready
// signals of the router-to-NOU output interface unit.
//   slave  : the interface unit (receives flits and ready, drives the NOU fields,
//            valid, yummy and overflow)
//   master : the environment (router + NOU side)
// Signals:
//   router_noiu_data   [WIDTH]      flit from router
//   router_noiu_valid               flit valid (no backpressure)
//   noiu_router_yummy               credit return pulse
//   noiu_nou_tid       [TID_WIDTH]  head flit tid field
//   noiu_nou_type      [TYPE_WIDTH] head flit type field
//   noiu_nou_data      [DAT_WIDTH]  head flit payload field
//   noiu_nou_valid                  head flit valid
//   nou_noiu_ready                  NOU accepts head flit
//   noiu_overflow                   sticky overflow flag

`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif
`ifndef TYPE_WIDTH
`define TYPE_WIDTH 4
`endif
`ifndef DAT_DAT_WIDTH
`define DAT_DAT_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface nou_out_interface_unit_if #(
    parameter int WIDTH     = `DATA_WIDTH,
    parameter int DAT_WIDTH = `DAT_DAT_WIDTH
);
    logic [WIDTH-1:0]       router_noiu_data;
    logic                   router_noiu_valid;
    logic                   noiu_router_yummy;
    logic [`TID_WIDTH-1:0]  noiu_nou_tid;
    logic [`TYPE_WIDTH-1:0] noiu_nou_type;
    logic [DAT_WIDTH-1:0]   noiu_nou_data;
    logic                   noiu_nou_valid;
    logic                   nou_noiu_ready;
    logic                   noiu_overflow;

    modport slave (
        input  router_noiu_data,
        input  router_noiu_valid,
        input  nou_noiu_ready,
        output noiu_router_yummy,
        output noiu_nou_tid,
        output noiu_nou_type,
        output noiu_nou_data,
        output noiu_nou_valid,
        output noiu_overflow
    );

    modport master (
        output router_noiu_data,
        output router_noiu_valid,
        output nou_noiu_ready,
        input  noiu_router_yummy,
        input  noiu_nou_tid,
        input  noiu_nou_type,
        input  noiu_nou_data,
        input  noiu_nou_valid,
        input  noiu_overflow
    );
endinterface

// File: rtl/nou_out_interface_unit.sv
// nou_out_interface_unit
// Router-to-NOU output interface. Flits arriving under the credit
// (valid/yummy) protocol are buffered in a DEPTH-entry FIFO and presented to
// the NOU as a show-ahead valid/ready stream split into tid/type/data fields.
// One yummy is returned to the router for every flit the NOU consumes.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : nou_out_interface_unit_if.slave (router flit/valid/yummy,
//          NOU tid/type/data/valid/ready, sticky overflow)

`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif
`ifndef TYPE_WIDTH
`define TYPE_WIDTH 4
`endif
`ifndef DAT_DAT_WIDTH
`define DAT_DAT_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module nou_out_interface_unit #(
    parameter int WIDTH     = `DATA_WIDTH,
    parameter int DAT_WIDTH = `DAT_DAT_WIDTH,
    parameter int DEPTH     = 2
) (
    input  logic clk,
    input  logic rst,
    nou_out_interface_unit_if.slave bus
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int TID_W    = `TID_WIDTH;
    localparam int TYPE_W   = `TYPE_WIDTH;
    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   count;
    logic                yummy;
    logic                overflow;

    logic                full;
    logic                valid;
    logic                push;
    logic                pop;
    logic [WIDTH-1:0]    head;

    // A flit may still be accepted when full if the head leaves in the same
    // cycle; the slot it frees is the one the new flit lands in.
    always_comb begin
        full  = (count == FULL_COUNT);
        valid = (count != '0);
        pop   = valid & bus.nou_noiu_ready;
        push  = bus.router_noiu_valid & (~full | pop);
        head  = valid ? mem[rd_ptr] : '0;
    end

    assign bus.noiu_nou_valid    = valid;
    assign bus.noiu_nou_tid      = head[WIDTH-1 -: TID_W];
    assign bus.noiu_nou_type     = head[WIDTH-TID_W-1 -: TYPE_W];
    assign bus.noiu_nou_data     = head[DAT_WIDTH-1:0];
    assign bus.noiu_router_yummy = yummy;
    assign bus.noiu_overflow     = overflow;

    // Storage is deliberately not reset; count gates everything read from it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.router_noiu_data;
        end
    end

    // Pointers wrap modulo DEPTH on their own because DEPTH is a power of 2.
    // Yummy mirrors the pop one cycle later so every consumed flit returns
    // exactly one credit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            yummy    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            count <= count + (PTR_BITS+1)'(push) - (PTR_BITS+1)'(pop);
            yummy <= pop;
            if (bus.router_noiu_valid & full & ~pop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nou_out_interface_unit.sv
// tb_nou_out_interface_unit
// Directed bench for nou_out_interface_unit (DEPTH=2, 4/4/8-bit fields).
// The driver pushes each flit it expects the DUT to accept into a queue; a
// monitor on the falling edge pops and compares whenever valid & ready, and
// checks that yummy follows every pop by exactly one cycle.

module tb_nou_out_interface_unit;
    logic clk;
    logic rst;

    nou_out_interface_unit_if #(.WIDTH(16), .DAT_WIDTH(8)) bus ();

    nou_out_interface_unit #(.WIDTH(16), .DAT_WIDTH(8), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pops_seen = 0;
    int yummies_seen = 0;
    logic [15:0] exp_q [$];
    logic prev_pop = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one flit for one cycle; accept says whether it should enter the FIFO.
    task automatic apply_stimulus(input logic v, input logic [15:0] flit,
                                  input logic rdy, input logic accept);
        bus.router_noiu_valid = v;
        bus.router_noiu_data  = flit;
        bus.nou_noiu_ready    = rdy;
        if (v && accept) exp_q.push_back(flit);
        tick();
        bus.router_noiu_valid = 1'b0;
    endtask

    task automatic check_head(input string name, input logic [15:0] flit);
        check_output({name, "_valid"}, 32'(bus.noiu_nou_valid), 32'd1);
        check_output({name, "_fields"},
                     32'({bus.noiu_nou_tid, bus.noiu_nou_type, bus.noiu_nou_data}),
                     32'(flit));
    endtask

    task automatic wait_drain();
        bus.nou_noiu_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        check_output("drain_empty", 32'(exp_q.size()), 32'd0);
        check_output("drain_valid", 32'(bus.noiu_nou_valid), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_output("rst_async_valid", 32'(bus.noiu_nou_valid), 32'd0);
        tick();
        rst = 1'b1;
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check_output("mon_rst_outputs",
                         32'({bus.noiu_nou_valid, bus.noiu_router_yummy, bus.noiu_overflow}), 32'd0);
            check_output("mon_rst_fields",
                         32'({bus.noiu_nou_tid, bus.noiu_nou_type, bus.noiu_nou_data}), 32'd0);
            prev_pop = 1'b0;
        end else begin
            check_output("mon_yummy", 32'(bus.noiu_router_yummy), 32'(prev_pop));
            if (bus.noiu_router_yummy) yummies_seen++;
            if (!bus.noiu_nou_valid)
                check_output("mon_empty_fields",
                             32'({bus.noiu_nou_tid, bus.noiu_nou_type, bus.noiu_nou_data}), 32'd0);
            if (bus.noiu_nou_valid && bus.nou_noiu_ready) begin
                pops_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL mon_unexpected_flit: got %h expected none",
                             {bus.noiu_nou_tid, bus.noiu_nou_type, bus.noiu_nou_data});
                end else begin
                    check_output("mon_flit",
                                 32'({bus.noiu_nou_tid, bus.noiu_nou_type, bus.noiu_nou_data}),
                                 32'(exp_q.pop_front()));
                end
            end
            prev_pop = bus.noiu_nou_valid && bus.nou_noiu_ready;
        end
    end

    initial begin
        int pops_before;
        int yum_before;
        rst = 1'b0;
        bus.router_noiu_valid = 1'b0;
        bus.router_noiu_data  = '0;
        bus.nou_noiu_ready    = 1'b0;

        // Reset with router valid toggling: nothing may enter.
        for (int i = 0; i < 4; i++) begin
            bus.router_noiu_valid = 1'(i % 2);
            bus.router_noiu_data  = 16'hBEEF;
            tick();
        end
        check_output("rst_valid", 32'(bus.noiu_nou_valid), 32'd0);
        bus.router_noiu_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_output("post_rst_valid", 32'(bus.noiu_nou_valid), 32'd0);
        check_output("post_rst_yummy", 32'(bus.noiu_router_yummy), 32'd0);

        // Single flit tid=3 type=1 data=A5: visible next cycle, yummy one after.
        apply_stimulus(1'b1, 16'h31A5, 1'b1, 1'b1);
        check_head("single", 16'h31A5);
        check_output("single_no_yummy_yet", 32'(bus.noiu_router_yummy), 32'd0);
        tick();
        check_output("single_yummy", 32'(bus.noiu_router_yummy), 32'd1);
        check_output("single_gone", 32'(bus.noiu_nou_valid), 32'd0);
        tick();
        check_output("single_yummy_once", 32'(bus.noiu_router_yummy), 32'd0);

        // Backpressure: head holds F0, then F0,F1 leave back to back.
        apply_stimulus(1'b1, 16'h1211, 1'b0, 1'b1);
        apply_stimulus(1'b1, 16'h2422, 1'b0, 1'b1);
        check_head("bp_hold0", 16'h1211);
        check_output("bp_no_yummy", 32'(bus.noiu_router_yummy), 32'd0);
        tick();
        check_head("bp_hold1", 16'h1211);
        bus.nou_noiu_ready = 1'b1;
        tick();
        check_head("bp_second", 16'h2422);
        check_output("bp_yummy0", 32'(bus.noiu_router_yummy), 32'd1);
        tick();
        check_output("bp_yummy1", 32'(bus.noiu_router_yummy), 32'd1);
        check_output("bp_empty", 32'(bus.noiu_nou_valid), 32'd0);
        tick();
        check_output("bp_yummy_end", 32'(bus.noiu_router_yummy), 32'd0);

        // Full FIFO with simultaneous push and pop.
        apply_stimulus(1'b1, 16'h5A01, 1'b0, 1'b1);
        apply_stimulus(1'b1, 16'h6B02, 1'b0, 1'b1);
        apply_stimulus(1'b1, 16'h7C03, 1'b1, 1'b1);
        bus.nou_noiu_ready = 1'b0;
        check_head("pp_head", 16'h6B02);
        check_output("pp_no_overflow", 32'(bus.noiu_overflow), 32'd0);
        wait_drain();

        // Overflow: third flit dropped, flag sticky, head untouched.
        apply_stimulus(1'b1, 16'h8D10, 1'b0, 1'b1);
        apply_stimulus(1'b1, 16'h9E20, 1'b0, 1'b1);
        apply_stimulus(1'b1, 16'hAF30, 1'b0, 1'b0);
        check_output("ovf_set", 32'(bus.noiu_overflow), 32'd1);
        check_head("ovf_head", 16'h8D10);
        wait_drain();
        check_output("ovf_sticky", 32'(bus.noiu_overflow), 32'd1);
        pulse_reset();
        check_output("ovf_cleared", 32'(bus.noiu_overflow), 32'd0);

        // Stream of 8 flits with ready held high.
        pops_before = pops_seen;
        yum_before  = yummies_seen;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 16'hC000 + 16'(i * 16'h0111), 1'b1, 1'b1);
        end
        wait_drain();
        check_output("stream_pops", 32'(pops_seen - pops_before), 32'd8);
        check_output("stream_yummies", 32'(yummies_seen - yum_before), 32'd8);

        // Reset with two flits buffered: they vanish and return no credit.
        yum_before = yummies_seen;
        apply_stimulus(1'b1, 16'hD111, 1'b0, 1'b1);
        apply_stimulus(1'b1, 16'hE222, 1'b0, 1'b1);
        check_head("rst_mid_head", 16'hD111);
        pulse_reset();
        bus.nou_noiu_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_output("rst_mid_valid", 32'(bus.noiu_nou_valid), 32'd0);
        check_output("rst_mid_no_yummy", 32'(yummies_seen - yum_before), 32'd0);
        check_output("total_credit_balance", 32'(yummies_seen), 32'(pops_seen));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end
endmodule
